wired_iq_entry_wakeup: RTL

Parametrised single issue-queue entry with per-operand readiness tracking. It holds one instruction payload plus NUM_SRC source tags. Readiness comes from NUM_WKUP wakeup broadcast ports, each with a programmable producer latency. The entry supports issue, replay and flush. It is instantiated once per slot inside the issue queue, between the rename/dispatch stage and the select arbiter.

---
 rtl/wired_iq_entry_wakeup.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wired_iq_entry_wakeup.sv
// Single issue-queue slot: holds one instruction and tracks per-source readiness
// from dispatch state plus latency-tagged wakeup broadcasts; supports issue/replay/flush.
module wired_iq_entry_wakeup #(
  parameter int PAYLOAD_SIZE = 32,
  parameter int NUM_SRC      = 2,
  parameter int TAG_W        = 6,
  parameter int NUM_WKUP     = 4,
  parameter int LAT_W        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      update_i,
  input  logic [PAYLOAD_SIZE-1:0]   payload_i,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag_i,
  input  logic [NUM_SRC-1:0]        src_rdy_i,
  input  logic [NUM_WKUP-1:0]       wkup_valid_i,
  input  logic [NUM_WKUP*TAG_W-1:0] wkup_tag_i,
  input  logic [NUM_WKUP*LAT_W-1:0] wkup_lat_i,
  input  logic                      sel_i,
  input  logic                      done_i,
  input  logic                      replay_i,
  output logic [PAYLOAD_SIZE-1:0]   payload_o,
  output logic [NUM_SRC-1:0]        src_rdy_o,
  output logic                      ready_o,
  output logic                      empty_o
);

  typedef enum logic [1:0] {EMPTY, WAIT, ISSUED} state_t;

  state_t                  state_reg, state_next;
  logic                    ready_reg, ready_next;
  logic                    empty_reg, empty_next;
  logic [PAYLOAD_SIZE-1:0] payload_reg;
  logic [NUM_SRC-1:0]      rdy_vec, rdy_next_vec;
  logic                    wake_en;
  logic                    do_replay;

  assign wake_en   = update_i | (state_reg != EMPTY);
  assign do_replay = (state_reg == ISSUED) & replay_i & ~update_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
      empty_reg <= empty_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = EMPTY;
    end else if (update_i) begin
      state_next = WAIT;
    end else begin
      case (state_reg)
        WAIT:    if (sel_i && ready_reg) state_next = ISSUED;
        // replay takes precedence over a simultaneous done
        ISSUED:  if (replay_i) state_next = WAIT;
                 else if (done_i) state_next = EMPTY;
        default: state_next = state_reg;
      endcase
    end
    ready_next = (state_next == WAIT) && (&rdy_next_vec);
    empty_next = (state_next == EMPTY);
  end

  always_ff @(posedge clk) begin
    if (update_i && !flush_i) payload_reg <= payload_i;
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [TAG_W-1:0] tag_reg;
    logic [TAG_W-1:0] cmp_tag;
    logic             rdy_reg, rdy_next;
    logic             pend_reg, pend_next;
    logic             woke_reg, woke_next;
    logic [LAT_W-1:0] cnt_reg, cnt_next;
    logic             hit;
    logic [LAT_W-1:0] hit_lat;

    // dispatch bypass: a broadcast during update matches the incoming tag
    assign cmp_tag = update_i ? src_tag_i[gi*TAG_W +: TAG_W] : tag_reg;

    always_comb begin
      hit     = 1'b0;
      hit_lat = '0;
      for (int k = 0; k < NUM_WKUP; k++) begin
        if (!hit && wkup_valid_i[k] && (wkup_tag_i[k*TAG_W +: TAG_W] == cmp_tag)) begin
          hit     = 1'b1;
          hit_lat = wkup_lat_i[k*LAT_W +: LAT_W];
        end
      end
    end

    always_comb begin
      rdy_next  = rdy_reg;
      pend_next = pend_reg;
      woke_next = woke_reg;
      cnt_next  = cnt_reg;
      if (flush_i) begin
        rdy_next  = 1'b0;
        pend_next = 1'b0;
        woke_next = 1'b0;
        cnt_next  = '0;
      end else if (update_i) begin
        rdy_next  = src_rdy_i[gi];
        pend_next = 1'b0;
        woke_next = 1'b0;
        cnt_next  = '0;
        if (hit && !src_rdy_i[gi]) begin
          if (hit_lat == '0) begin
            rdy_next  = 1'b1;
            woke_next = 1'b1;
          end else begin
            pend_next = 1'b1;
            cnt_next  = hit_lat;
          end
        end
      end else if (do_replay && woke_reg) begin
        rdy_next  = 1'b0;
        pend_next = 1'b0;
        woke_next = 1'b0;
      end else if (pend_reg) begin
        if (cnt_reg == LAT_W'(1)) begin
          rdy_next  = 1'b1;
          woke_next = 1'b1;
          pend_next = 1'b0;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end else if (wake_en && hit && !rdy_reg) begin
        if (hit_lat == '0) begin
          rdy_next  = 1'b1;
          woke_next = 1'b1;
        end else begin
          pend_next = 1'b1;
          cnt_next  = hit_lat;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdy_reg  <= 1'b0;
        pend_reg <= 1'b0;
        woke_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        rdy_reg  <= rdy_next;
        pend_reg <= pend_next;
        woke_reg <= woke_next;
        cnt_reg  <= cnt_next;
      end
    end

    always_ff @(posedge clk) begin
      if (update_i && !flush_i) tag_reg <= src_tag_i[gi*TAG_W +: TAG_W];
    end

    assign rdy_vec[gi]      = rdy_reg;
    assign rdy_next_vec[gi] = rdy_next;
  end

  assign payload_o = payload_reg;
  assign src_rdy_o = rdy_vec;
  assign ready_o   = ready_reg;
  assign empty_o   = empty_reg;

endmodule
